// File: rtl/detector_jogada.sv
// rtl/detector_jogada.sv - switch debouncer and one-hot play classifier
module detector_jogada #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       habilita,
   input  logic [3:0] chaves,
   output logic [3:0] jogada,
   output logic       jogada_feita,
   output logic       jogada_invalida,
   output logic       tem_jogada,
   output logic [2:0] db_estado
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [2:0] {
      OCIOSO        = 3'd0,
      FILTRANDO     = 3'd1,
      REGISTRA      = 3'd2,
      ESPERA_SOLTAR = 3'd3
   } estado_t;

   estado_t        estado_q, estado_d;
   logic [3:0]     amostra_q, amostra_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [3:0]     jogada_q, jogada_d;
   logic           valida_q, valida_d;

   function automatic logic one_hot(input logic [3:0] v);
      return (v == 4'b0001) || (v == 4'b0010) || (v == 4'b0100) || (v == 4'b1000);
   endfunction

   // state and datapath registers; reset wins over every transition
   always_ff @(posedge clock) begin
      if (!reset) begin
         estado_q  <= OCIOSO;
         amostra_q <= 4'd0;
         cnt_q     <= '0;
         jogada_q  <= 4'd0;
         valida_q  <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         amostra_q <= amostra_d;
         cnt_q     <= cnt_d;
         jogada_q  <= jogada_d;
         valida_q  <= valida_d;
      end
   end

   // next-state logic: filter a stable press, classify it, then wait for release
   always_comb begin
      estado_d  = estado_q;
      amostra_d = amostra_q;
      cnt_d     = cnt_q;
      jogada_d  = jogada_q;
      valida_d  = valida_q;
      case (estado_q)
         OCIOSO: begin
            if (habilita && (chaves != 4'd0)) begin
               amostra_d = chaves;
               cnt_d     = CNT_ONE;
               estado_d  = FILTRANDO;
            end
         end
         FILTRANDO: begin
            if (!habilita || (chaves == 4'd0)) begin
               estado_d = OCIOSO;
            end else if (chaves != amostra_q) begin
               // any change restarts the filter, even on the completing edge
               amostra_d = chaves;
               cnt_d     = CNT_ONE;
            end else if (cnt_q == CNT_LAST) begin
               estado_d = REGISTRA;
               valida_d = one_hot(amostra_q);
               if (one_hot(amostra_q)) begin
                  jogada_d = amostra_q;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         REGISTRA: begin
            estado_d = ESPERA_SOLTAR;
            cnt_d    = '0;
         end
         ESPERA_SOLTAR: begin
            if (chaves != 4'd0) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               estado_d = OCIOSO;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            estado_d = OCIOSO;
         end
      endcase
   end

   assign jogada          = jogada_q;
   assign jogada_feita    = (estado_q == REGISTRA) && valida_q;
   assign jogada_invalida = (estado_q == REGISTRA) && !valida_q;
   assign tem_jogada      = (estado_q == REGISTRA) || (estado_q == ESPERA_SOLTAR);
   assign db_estado       = estado_q;

endmodule

// File: doc/detector_jogada.md
# detector_jogada

Input-conditioning stage between the player's raw switches and the game datapath/FSM. It debounces `chaves`, waits for a stable non-zero pattern, and classifies it as a valid one-hot play or an invalid multi-key press. It emits a single-cycle strobe with the latched play, then waits for full release before accepting another press. Its `jogada` and `jogada_feita` outputs feed the comparator and control unit; `tem_jogada` drives the `db_tem_jogada` debug output.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive identical samples required to accept a press or a release. Legal range is 2..15.
- `clock`  in  1  system clock (50 MHz); all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `habilita`  in  1  from the control FSM; a new press is accepted only while high.
- `chaves`  in  4  raw switch inputs, asynchronous to nothing (driven at negedge in sim).
- `jogada`  out  4  last valid one-hot play, registered; holds until the next valid play or reset.
- `jogada_feita`  out  1  one-cycle strobe: `jogada` has just been updated with a valid play.
- `jogada_invalida`  out  1  one-cycle strobe: the stable pattern was not one-hot.
- `tem_jogada`  out  1  high from acceptance until release is confirmed.
- `db_estado`  out  3  current FSM state code.

## Operation
- FSM states and codes: OCIOSO=0, FILTRANDO=1, REGISTRA=2, ESPERA_SOLTAR=3.
- Internal registers:
  - `amostra[3:0]`: candidate pattern.
  - `cnt`: width ceil(log2(DEBOUNCE_CYCLES))+1, saturates at no value and is always reloaded explicitly.
- OCIOSO:
  - If `chaves`!=0 and `habilita`=1: `amostra`<=`chaves`, `cnt`<=1, go to FILTRANDO.
  - Otherwise stay. A non-zero `chaves` with `habilita`=0 is ignored each cycle.
- FILTRANDO, checked in priority order:
  - (a) `habilita`=0 or `chaves`=0: go to OCIOSO.
  - (b) `chaves`!=`amostra`: `amostra`<=`chaves`, `cnt`<=1, stay (restart filter).
  - (c) `cnt`=DEBOUNCE_CYCLES-1: go to REGISTRA. If `amostra` is one-hot, `jogada`<=`amostra`.
  - (d) else `cnt`<=`cnt`+1.
- REGISTRA, exactly one cycle:
  - `jogada_feita`=1 if `amostra` is one-hot; else `jogada_invalida`=1.
  - Unconditionally go to ESPERA_SOLTAR with `cnt`<=0.
- ESPERA_SOLTAR:
  - `chaves`!=0: `cnt`<=0.
  - `chaves`=0: `cnt`<=`cnt`+1. When `cnt`=DEBOUNCE_CYCLES-1, go to OCIOSO.
  - `habilita` is ignored in this state.
- One-hot test: exactly one of the 4 bits set, i.e. 0001, 0010, 0100 or 1000.
- Output decode:
  - `tem_jogada` = state in {REGISTRA, ESPERA_SOLTAR}.
  - Strobes are decoded from the state register plus a registered one-hot flag, so there are no combinational paths from `chaves`.

## Timing
- Reset (`reset`=0 at an edge): state OCIOSO, `jogada`=0000, `amostra`=0000, `cnt`=0. All outputs are 0 in the following cycle.
- Reset has priority over every transition, including mid-filter and mid-release.
- A key held through reset release is treated as a new press (if `habilita`=1).
- Acceptance latency:
  - Let E0 be the first edge that samples the stable non-zero value.
  - REGISTRA is entered at edge E(DEBOUNCE_CYCLES-1).
  - `jogada_feita` and the new `jogada` are visible in the cycle after that edge.
  - Default: 4 edges. A 5-cycle hold is therefore sufficient.
- Glitches: any change during FILTRANDO restarts the count. A single-cycle glitch shorter than DEBOUNCE_CYCLES never produces a strobe.
- A pattern change on the same edge that `cnt` would complete takes rule (b): restart, no strobe.
- Release latency: `tem_jogada` falls DEBOUNCE_CYCLES edges after the first zero sample. Bounce during release restarts the release count.
- At most one strobe, `jogada_feita` or `jogada_invalida`, per press. The two are never high together.

## Test plan
1. **Reset.** `reset`=0 for 1 cycle with `chaves`=0100 → next cycle `jogada`=0000, `db_estado`=0, all strobes 0.
2. **Valid press.** `habilita`=1, `chaves`=0010 held 10 cycles then 0000 → exactly one `jogada_feita` pulse 4 edges after the first sample, `jogada`=0010. `tem_jogada` falls 4 edges after release and `db_estado` returns to 0.
3. **Bounce.** `chaves` sequence 0001,0000,0001,0001,0001,0001 → no strobe until the final 4 stable samples, then one pulse with `jogada`=0001.
4. **Invalid press.** `chaves`=0110 held 10 cycles → one `jogada_invalida` pulse, `jogada_feita`=0, `jogada` keeps its previous value (0010).
5. **Disabled.** `habilita`=0 while `chaves`=1000 held 10 cycles → `db_estado` stays 0, no strobe. Then raise `habilita` with the key still held → `jogada_feita` after 4 edges, `jogada`=1000.
6. **Reset mid-filter and mid-release.** Assert `reset` after 2 stable samples → no strobe, state 0. Assert `reset` in ESPERA_SOLTAR → `tem_jogada`=0 next cycle, `jogada`=0000.
